// File: rtl/video_timing_pkg.sv
// Shared mode presets, sync polarity constants and axis flag bundle for the
// raster timing generator.
package video_timing_pkg;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    // 640x480@60 with 8-pixel/8-line borders
    localparam int VGA640_H_VISIBLE      = 640;
    localparam int VGA640_H_RIGHT_BORDER = 8;
    localparam int VGA640_H_FRONT_PORCH  = 8;
    localparam int VGA640_H_SYNC_TIME    = 96;
    localparam int VGA640_H_BACK_PORCH   = 40;
    localparam int VGA640_H_LEFT_BORDER  = 8;
    localparam int VGA640_V_VISIBLE      = 480;
    localparam int VGA640_V_BOTTOM_BORDER = 8;
    localparam int VGA640_V_FRONT_PORCH  = 2;
    localparam int VGA640_V_SYNC_TIME    = 2;
    localparam int VGA640_V_BACK_PORCH   = 25;
    localparam int VGA640_V_TOP_BORDER   = 8;

    typedef struct packed {
        logic sync;
        logic blank;
        logic border;
        logic start;
    } axis_flags_t;

    // A counter of width w holds 0..total-1 exactly when total <= 2**w.
    function automatic bit width_ok(input int total, input int w);
        return $clog2(total) <= w;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter advanced by step, plus registered
// sync/blank/border/start decode aligned with the registered position.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int VISIBLE      = 640,
    parameter int TRAIL_BORDER = 8,
    parameter int FRONT_PORCH  = 8,
    parameter int SYNC_TIME    = 96,
    parameter int BACK_PORCH   = 40,
    parameter int LEAD_BORDER  = 8,
    parameter bit POL          = POL_LOW,
    parameter int W            = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic         wrap,
    output logic [W-1:0] pos,
    output axis_flags_t  flags
);

    localparam int BLANK_START = VISIBLE + TRAIL_BORDER;
    localparam int SYNC_START  = BLANK_START + FRONT_PORCH;
    localparam int SYNC_END    = SYNC_START + SYNC_TIME;
    localparam int TOTAL       = SYNC_END + BACK_PORCH + LEAD_BORDER;
    localparam int LEAD_START  = TOTAL - LEAD_BORDER;

    generate
        if (!width_ok(TOTAL, W) || SYNC_TIME == 0) begin : g_bad_cfg
            $error("video_axis_counter: TOTAL-1 does not fit W bits or SYNC_TIME is zero");
        end
    endgenerate

    logic [W-1:0] cnt;
    logic [31:0]  cnt32;

    // Decode at 32 bits so boundaries equal to 2**W cannot alias to zero.
    assign cnt32 = 32'(cnt);
    assign wrap  = (cnt == W'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            pos          <= '0;
            flags.sync   <= ~POL;
            flags.blank  <= 1'b1;
            flags.border <= 1'b0;
            flags.start  <= 1'b0;
        end else begin
            if (step) begin
                cnt <= wrap ? '0 : cnt + W'(1);
            end
            pos          <= cnt;
            flags.sync   <= (cnt32 >= SYNC_START && cnt32 < SYNC_END) ? POL : ~POL;
            flags.blank  <= (cnt32 >= VISIBLE);
            flags.border <= (cnt32 >= VISIBLE && cnt32 < BLANK_START) ||
                            (LEAD_BORDER != 0 && cnt32 >= LEAD_START);
            flags.start  <= (cnt == '0);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal and vertical axis counters combined into
// sync, blank, border, display-enable, line/frame strobes and a frame counter.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE       = VGA640_H_VISIBLE,
    parameter int H_RIGHT_BORDER  = VGA640_H_RIGHT_BORDER,
    parameter int H_FRONT_PORCH   = VGA640_H_FRONT_PORCH,
    parameter int H_SYNC_TIME     = VGA640_H_SYNC_TIME,
    parameter int H_BACK_PORCH    = VGA640_H_BACK_PORCH,
    parameter int H_LEFT_BORDER   = VGA640_H_LEFT_BORDER,
    parameter int V_VISIBLE       = VGA640_V_VISIBLE,
    parameter int V_BOTTOM_BORDER = VGA640_V_BOTTOM_BORDER,
    parameter int V_FRONT_PORCH   = VGA640_V_FRONT_PORCH,
    parameter int V_SYNC_TIME     = VGA640_V_SYNC_TIME,
    parameter int V_BACK_PORCH    = VGA640_V_BACK_PORCH,
    parameter int V_TOP_BORDER    = VGA640_V_TOP_BORDER,
    parameter bit H_SYNC_POL      = POL_LOW,
    parameter bit V_SYNC_POL      = POL_LOW,
    parameter int HPOS_W          = 10,
    parameter int VPOS_W          = 10,
    parameter int FRAME_W         = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_hblank,
    output logic               o_vblank,
    output logic               o_display_on,
    output logic               o_border,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [HPOS_W-1:0]  o_hpos,
    output logic [VPOS_W-1:0]  o_vpos,
    output logic [FRAME_W-1:0] o_frame
);

    logic        h_wrap;
    logic        v_wrap;
    logic        origin_next;
    axis_flags_t h_flags;
    axis_flags_t v_flags;

    video_axis_counter #(
        .VISIBLE(H_VISIBLE), .TRAIL_BORDER(H_RIGHT_BORDER), .FRONT_PORCH(H_FRONT_PORCH),
        .SYNC_TIME(H_SYNC_TIME), .BACK_PORCH(H_BACK_PORCH), .LEAD_BORDER(H_LEFT_BORDER),
        .POL(H_SYNC_POL), .W(HPOS_W)
    ) u_h_axis (
        .clk(i_clk), .rst_n(i_rst_n), .step(1'b1),
        .wrap(h_wrap), .pos(o_hpos), .flags(h_flags)
    );

    video_axis_counter #(
        .VISIBLE(V_VISIBLE), .TRAIL_BORDER(V_BOTTOM_BORDER), .FRONT_PORCH(V_FRONT_PORCH),
        .SYNC_TIME(V_SYNC_TIME), .BACK_PORCH(V_BACK_PORCH), .LEAD_BORDER(V_TOP_BORDER),
        .POL(V_SYNC_POL), .W(VPOS_W)
    ) u_v_axis (
        .clk(i_clk), .rst_n(i_rst_n), .step(h_wrap),
        .wrap(v_wrap), .pos(o_vpos), .flags(v_flags)
    );

    // origin_next marks that the pixel presented at the next edge is (0,0) of a
    // continuing raster; it stays clear after reset so the first frame is 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            origin_next <= 1'b0;
            o_frame     <= '0;
        end else begin
            origin_next <= h_wrap && v_wrap;
            if (origin_next) begin
                o_frame <= o_frame + FRAME_W'(1);
            end
        end
    end

    assign o_hsync       = h_flags.sync;
    assign o_vsync       = v_flags.sync;
    assign o_hblank      = h_flags.blank;
    assign o_vblank      = v_flags.blank;
    assign o_display_on  = ~h_flags.blank & ~v_flags.blank;
    assign o_border      = h_flags.border | v_flags.border;
    assign o_line_start  = h_flags.start;
    assign o_frame_start = h_flags.start & v_flags.start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised-reset bench for video_timing_gen on a small raster, checked every
// cycle against a pixel-position reference model.
module tb_video_timing_gen;

    localparam int HV = 10, HRB = 2, HFP = 2, HST = 3, HBP = 2, HLB = 2;
    localparam int VV = 6,  VBB = 1, VFP = 1, VST = 2, VBP = 1, VTB = 1;
    localparam int HSS = HV + HRB + HFP;
    localparam int HSE = HSS + HST;
    localparam int HT  = HSE + HBP + HLB;
    localparam int VSS = VV + VBB + VFP;
    localparam int VSE = VSS + VST;
    localparam int VT  = VSE + VBP + VTB;
    localparam bit HP  = 1'b1;
    localparam bit VP  = 1'b0;
    localparam int HW  = 5, VW = 4, FW = 2;
    localparam int N_CYCLES = 30000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hsync, vsync, hblank, vblank, display_on, border, line_start, frame_start;
    logic [HW-1:0] hpos;
    logic [VW-1:0] vpos;
    logic [FW-1:0] frame;

    video_timing_gen #(
        .H_VISIBLE(HV), .H_RIGHT_BORDER(HRB), .H_FRONT_PORCH(HFP), .H_SYNC_TIME(HST),
        .H_BACK_PORCH(HBP), .H_LEFT_BORDER(HLB),
        .V_VISIBLE(VV), .V_BOTTOM_BORDER(VBB), .V_FRONT_PORCH(VFP), .V_SYNC_TIME(VST),
        .V_BACK_PORCH(VBP), .V_TOP_BORDER(VTB),
        .H_SYNC_POL(HP), .V_SYNC_POL(VP), .HPOS_W(HW), .VPOS_W(VW), .FRAME_W(FW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_hsync(hsync), .o_vsync(vsync), .o_hblank(hblank), .o_vblank(vblank),
        .o_display_on(display_on), .o_border(border),
        .o_line_start(line_start), .o_frame_start(frame_start),
        .o_hpos(hpos), .o_vpos(vpos), .o_frame(frame)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the pixel currently shown, or idle while in reset.
    bit idle = 1'b1;
    int x = 0, y = 0, fcount = 0;
    int last_fs = -1;
    int n_frames = 0;
    int n_resets = 0;

    initial begin
        int hold;
        logic [7:0] e;
        hold = 3;
        for (int c = 0; c < N_CYCLES; c++) begin
            @(posedge clk);
            if (!rst_n) begin
                idle = 1'b1;
            end else if (idle) begin
                idle = 1'b0; x = 0; y = 0; fcount = 0;
            end else begin
                x++;
                if (x == HT) begin
                    x = 0;
                    y++;
                    if (y == VT) begin
                        y = 0;
                        fcount = (fcount + 1) % (1 << FW);
                    end
                end
            end

            @(negedge clk);
            if (idle) begin
                e = {~HP, ~VP, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            end else begin
                e[7] = (x >= HSS && x < HSE) ? HP : ~HP;
                e[6] = (y >= VSS && y < VSE) ? VP : ~VP;
                e[5] = (x >= HV);
                e[4] = (y >= VV);
                e[3] = (x < HV) && (y < VV);
                e[2] = (x >= HV && x < HV + HRB) || (x >= HT - HLB) ||
                       (y >= VV && y < VV + VBB) || (y >= VT - VTB);
                e[1] = (x == 0);
                e[0] = (x == 0) && (y == 0);
            end
            chk("flags", {hsync, vsync, hblank, vblank, display_on, border, line_start, frame_start}, e);
            chk("hpos", hpos, idle ? 0 : x);
            chk("vpos", vpos, idle ? 0 : y);
            chk("frame", frame, idle ? 0 : fcount);

            if (idle) begin
                last_fs = -1;
            end else if (x == 0 && y == 0) begin
                if (last_fs >= 0) begin
                    chk("frame_period", c - last_fs, HT * VT);
                    n_frames++;
                end
                last_fs = c;
            end

            if (hold > 0) begin
                rst_n = 1'b0;
                hold--;
            end else begin
                rst_n = 1'b1;
                if ($urandom_range(0, 1499) == 0) begin
                    hold = $urandom_range(1, 4);
                    n_resets++;
                end
            end
        end
        chk("frames_seen", (n_frames > 20) ? 1 : 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
